// File: rtl/mem_io_responder.sv
// Memory-mapped keyboard/timer responder: a STATUS/DATA/TIMER register window with
// a scan-code FIFO, a sticky overflow flag and a millisecond counter behind it.
module mem_io_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_PER_MS = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  memEn,
  input  logic [1:0]  memBank,
  input  logic        invAddr,
  input  logic [31:0] writeData,
  input  logic        kbdValid,
  input  logic [7:0]  kbdData,
  output logic [31:0] readData,
  output logic        dataReady,
  output logic        kbdIrq,
  output logic [1:0]  dbg_state_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, HOLD = 2'd2} state_e;
  typedef enum logic [1:0] {TGT_NONE, TGT_STATUS, TGT_DATA, TGT_TIMER} tgt_e;

  state_e        state_q, state_d;
  tgt_e          tgt_q, tgt_d, tgt_dec;
  logic          start;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic          ovf_q, ovf_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   ms_q, ms_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          fifo_empty, fifo_full, pop, push, ovf_set, ovf_clr, tmr_clr;
  logic [31:0]   occ_ext;
  logic [3:0]    occ_sat;
  logic          unused_wdata;

  // Store data carries no meaning for any register in this window.
  assign unused_wdata = ^writeData;

  always_comb begin
    tgt_dec = TGT_NONE;
    if ((memRead || memWrite) && !invAddr) begin
      if (memBank == 2'd2 && memEn == 3'b000)      tgt_dec = TGT_STATUS;
      else if (memBank == 2'd2 && memEn == 3'b100) tgt_dec = TGT_DATA;
      else if (memBank == 2'd3 && memEn == 3'b100) tgt_dec = TGT_TIMER;
    end
  end

  // Handshake: an access is held on memRead/memWrite until dataReady has pulsed; the
  // response is a single-cycle dataReady pulse with readData valid in the same cycle.
  // HOLD parks the FSM until the strobe is dropped so a held access acts only once.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tgt_dec != TGT_NONE) begin
          state_d = RESP;
          tgt_d   = tgt_dec;
          start   = 1'b1;
        end
      end
      RESP: state_d = HOLD;
      HOLD: begin
        if (tgt_dec != tgt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = start && (tgt_dec == TGT_DATA) && !memWrite && !fifo_empty;
  // A same-cycle pop frees the slot the push needs, so a full FIFO still accepts it.
  assign push       = kbdValid && (!fifo_full || pop);
  assign ovf_set    = kbdValid && fifo_full && !pop;
  assign ovf_clr    = start && (tgt_dec == TGT_STATUS);
  assign tmr_clr    = start && (tgt_dec == TGT_TIMER) && memWrite;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_set | (ovf_q & ~ovf_clr);

    if (tmr_clr) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (presc_q == PW'(CLK_PER_MS - 1)) begin
      presc_d = '0;
      ms_d    = ms_q + 32'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      ms_d    = ms_q;
    end

    occ_ext     = 32'(count_q);
    occ_sat     = (occ_ext > 32'd15) ? 4'hF : occ_ext[3:0];
    read_data_d = read_data_q;
    if (start) begin
      read_data_d = '0;
      if (!memWrite) begin
        unique case (tgt_dec)
          TGT_STATUS: read_data_d = {24'd0, occ_sat, 2'b00, ovf_q, !fifo_empty};
          TGT_DATA:   read_data_d = fifo_empty ? 32'd0 : {24'd0, fifo_mem_q[rd_ptr_q]};
          TGT_TIMER:  read_data_d = ms_q;
          default:    read_data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tgt_q       <= TGT_NONE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      presc_q     <= '0;
      ms_q        <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      read_data_q <= read_data_d;
    end
  end

  // Entry storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= kbdData;
  end

  assign readData    = read_data_q;
  assign dataReady   = (state_q == RESP);
  assign kbdIrq      = !fifo_empty;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus randomized traffic, checked
// against a queue-based model of the FIFO, overflow flag and millisecond timer.
module tb_mem_io_responder;
  localparam int DEPTH = 8;
  localparam int CPM   = 4;

  localparam int K_NONE  = 0;
  localparam int K_ST_RD = 1;
  localparam int K_ST_WR = 2;
  localparam int K_DA_RD = 3;
  localparam int K_DA_WR = 4;
  localparam int K_TM_RD = 5;
  localparam int K_TM_WR = 6;
  localparam int K_INV   = 7;
  localparam int K_BADEN = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        memRead = 1'b0, memWrite = 1'b0, invAddr = 1'b0, kbdValid = 1'b0;
  logic [2:0]  memEn = '0;
  logic [1:0]  memBank = '0;
  logic [31:0] writeData = '0;
  logic [7:0]  kbdData = '0;
  logic [31:0] readData;
  logic        dataReady, kbdIrq;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [7:0]  fifo_m[$];
  bit          ovf_m = 1'b0;
  int          edge_n = 0;
  int          t0 = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_io_responder #(.FIFO_DEPTH(DEPTH), .CLK_PER_MS(CPM)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .memEn(memEn), .memBank(memBank), .invAddr(invAddr), .writeData(writeData),
    .kbdValid(kbdValid), .kbdData(kbdData), .readData(readData),
    .dataReady(dataReady), .kbdIrq(kbdIrq), .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int kind);
    memRead = 1'b0; memWrite = 1'b0; invAddr = 1'b0;
    memBank = 2'd0; memEn = 3'b000; writeData = $urandom;
    case (kind)
      K_ST_RD: begin memRead = 1'b1;  memBank = 2'd2; memEn = 3'b000; end
      K_ST_WR: begin memWrite = 1'b1; memBank = 2'd2; memEn = 3'b000; end
      K_DA_RD: begin memRead = 1'b1;  memBank = 2'd2; memEn = 3'b100; end
      K_DA_WR: begin memWrite = 1'b1; memBank = 2'd2; memEn = 3'b100; end
      K_TM_RD: begin memRead = 1'b1;  memBank = 2'd3; memEn = 3'b100; end
      K_TM_WR: begin memWrite = 1'b1; memBank = 2'd3; memEn = 3'b100; end
      K_INV:   begin memRead = 1'b1;  memBank = 2'd2; memEn = 3'b100; invAddr = 1'b1; end
      K_BADEN: begin memRead = 1'b1;  memBank = 2'd2; memEn = 3'b010; end
      default: ;
    endcase
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // compare 1 time unit later. first marks the first cycle an access is presented.
  task automatic cycle(input int kind, input bit first, input bit push, input logic [7:0] pbyte);
    bit resp, clr, setv;
    int occ;
    drive(kind);
    kbdValid = push;
    kbdData  = pbyte;
    @(posedge clk);
    edge_n++;
    resp = first && (kind >= K_ST_RD) && (kind <= K_TM_WR);
    clr  = 1'b0;
    setv = 1'b0;
    if (resp) begin
      occ = fifo_m.size();
      case (kind)
        K_ST_RD: begin
          exp_q.push_back({24'd0, 4'((occ > 15) ? 15 : occ), 2'b00, ovf_m, occ != 0});
          clr = 1'b1;
        end
        K_ST_WR: clr = 1'b1;
        K_DA_RD: begin
          if (occ > 0) exp_q.push_back(32'(fifo_m.pop_front()));
          else exp_q.push_back(32'd0);
        end
        K_DA_WR: exp_q.push_back(32'd0);
        K_TM_RD: exp_q.push_back(32'((edge_n - 1 - t0) / CPM));
        K_TM_WR: t0 = edge_n;
        default: ;
      endcase
    end
    if (push) begin
      if (fifo_m.size() == DEPTH) setv = 1'b1;
      else fifo_m.push_back(pbyte);
    end
    ovf_m = setv | (ovf_m & ~clr);
    #1;
    check("dataReady", 32'(dataReady), 32'(resp));
    if (exp_q.size() != 0) check("readData", readData, exp_q.pop_front());
    check("kbdIrq", 32'(kbdIrq), 32'(fifo_m.size() != 0));
    @(negedge clk);
  endtask

  task automatic access(input int kind, input int hold, input int idle);
    for (int i = 0; i < hold; i++) cycle(kind, i == 0, 1'b0, 8'h00);
    for (int i = 0; i < idle; i++) cycle(K_NONE, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_byte(input logic [7:0] b);
    cycle(K_NONE, 1'b0, 1'b1, b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(K_NONE);
    kbdValid = 1'b0;
    #1;
    check("rst_readData", readData, 32'd0);
    check("rst_dataReady", 32'(dataReady), 32'd0);
    check("rst_kbdIrq", 32'(kbdIrq), 32'd0);
    fifo_m.delete();
    exp_q.delete();
    ovf_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t0 = edge_n;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Two pushes, DATA read held three cycles: one response with the head byte.
    push_byte(8'h1C);
    push_byte(8'h32);
    access(K_DA_RD, 3, 2);
    access(K_ST_RD, 1, 2);

    // Overflow: nine pushes into eight entries, then two STATUS reads.
    do_reset();
    for (int i = 0; i < 9; i++) push_byte(8'(8'h50 + i));
    access(K_ST_RD, 1, 2);
    access(K_ST_RD, 1, 2);

    // Full FIFO: push and pop in the same cycle, then drain to confirm order.
    cycle(K_DA_RD, 1'b1, 1'b1, 8'hA5);
    access(K_NONE, 0, 2);
    access(K_ST_RD, 1, 2);
    for (int i = 0; i < 9; i++) access(K_DA_RD, 1, 2);
    access(K_DA_WR, 2, 2);

    // Timer: 40 cycles then read, clear, and read again after four cycles.
    do_reset();
    access(K_NONE, 0, 40);
    access(K_TM_RD, 1, 2);
    access(K_TM_WR, 1, 4);
    access(K_TM_RD, 1, 2);

    // Accesses that do not belong to this block.
    push_byte(8'h11);
    push_byte(8'h22);
    access(K_INV, 2, 2);
    access(K_BADEN, 2, 2);
    access(K_ST_RD, 1, 2);

    // Reset while in RESP with three queued entries; access still held after release.
    do_reset();
    for (int i = 0; i < 3; i++) push_byte(8'(8'h40 + i));
    drive(K_DA_RD);
    kbdValid = 1'b0;
    @(posedge clk);
    edge_n++;
    #1;
    check("abort_pre_rdy", 32'(dataReady), 32'd1);
    check("abort_pre_rd", readData, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rdy", 32'(dataReady), 32'd0);
    check("abort_irq", 32'(kbdIrq), 32'd0);
    check("abort_rd", readData, 32'd0);
    fifo_m.delete();
    exp_q.delete();
    ovf_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t0 = edge_n;
    cycle(K_DA_RD, 1'b1, 1'b0, 8'h00);
    cycle(K_DA_RD, 1'b0, 1'b0, 8'h00);
    access(K_NONE, 0, 2);

    // Randomized traffic with background keyboard pushes.
    for (int n = 0; n < 250; n++) begin
      int kind, hold;
      kind = $urandom_range(0, 8);
      hold = $urandom_range(1, 3);
      for (int i = 0; i < hold; i++)
        cycle(kind, i == 0, $urandom_range(0, 2) == 0, 8'($urandom));
      for (int i = 0; i < 2; i++)
        cycle(K_NONE, 1'b0, $urandom_range(0, 2) == 0, 8'($urandom));
    end
    access(K_ST_RD, 1, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
